// File: rtl/mnist_run_controller.sv
// Run sequencer for the systolic-array MNIST wrapper: turns switch commands into
// load/start handshakes, steps images, decodes and scores one-hot results.
module mnist_run_controller #(
  parameter int N_IMAGES       = 16,
  parameter int IMG_W          = 4,
  parameter int NUM_CLASSES    = 10,
  parameter int TIMEOUT_CYCLES = 1048576,
  parameter int CNT_W          = $clog2(N_IMAGES + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cmd_load,
  input  logic                   cmd_run_one,
  input  logic                   cmd_sweep,
  input  logic [IMG_W-1:0]       sel_image,
  output logic                   sa_load_params,
  output logic                   sa_start_comp,
  output logic [IMG_W-1:0]       sa_image_num,
  input  logic                   sa_ready,
  input  logic [NUM_CLASSES-1:0] sa_classes,
  input  logic [3:0]             exp_label,
  output logic [3:0]             result_digit,
  output logic                   result_valid,
  output logic                   params_loaded,
  output logic                   busy,
  output logic                   onehot_err,
  output logic                   timeout_err,
  output logic [CNT_W-1:0]       done_cnt,
  output logic [CNT_W-1:0]       correct_cnt
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IMG_W-1:0] IMG_LAST = IMG_W'(N_IMAGES - 1);

  typedef enum logic [2:0] {
    IDLE, LOAD_REQ, LOAD_WAIT, RUN_REQ, RUN_WAIT, CAPTURE, NEXT
  } state_t;

  function automatic logic is_onehot(input logic [NUM_CLASSES-1:0] c);
    return (c != '0) && ((c & (c - NUM_CLASSES'(1))) == '0);
  endfunction

  function automatic logic [3:0] onehot_idx(input logic [NUM_CLASSES-1:0] c);
    logic [3:0] idx;
    idx = 4'h0;
    for (int i = 0; i < NUM_CLASSES; i++)
      if (c[i]) idx = 4'(i);
    return idx;
  endfunction

  // Bit order: {sa_ready, cmd_sweep, cmd_run_one, cmd_load}
  logic [3:0] sync1_q, sync2_q, prev_q;
  logic       edge_load, edge_run, edge_sweep, rdy_s;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= {sa_ready, cmd_sweep, cmd_run_one, cmd_load};
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign edge_load  = sync2_q[0] & ~prev_q[0];
  assign edge_run   = sync2_q[1] & ~prev_q[1];
  assign edge_sweep = sync2_q[2] & ~prev_q[2];
  assign rdy_s      = sync2_q[3];

  state_t            state_q;
  logic              load_q, start_q, sweep_q, rv_q, loaded_q, oh_err_q, to_err_q;
  logic [IMG_W-1:0]  img_q;
  logic [3:0]        digit_q;
  logic [CNT_W-1:0]  done_q, corr_q;
  logic [TMO_W-1:0]  tmo_q;
  logic              in_wait, tmo_hit, cls_ok;
  logic [3:0]        cls_idx;

  assign in_wait = (state_q == LOAD_REQ) || (state_q == LOAD_WAIT) ||
                   (state_q == RUN_REQ)  || (state_q == RUN_WAIT);
  assign tmo_hit = (tmo_q == TMO_LAST);
  assign cls_ok  = is_onehot(sa_classes);
  assign cls_idx = onehot_idx(sa_classes);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      load_q   <= 1'b0;
      start_q  <= 1'b0;
      sweep_q  <= 1'b0;
      rv_q     <= 1'b0;
      loaded_q <= 1'b0;
      oh_err_q <= 1'b0;
      to_err_q <= 1'b0;
      img_q    <= '0;
      digit_q  <= 4'hF;
      done_q   <= '0;
      corr_q   <= '0;
      tmo_q    <= '0;
    end else begin
      rv_q <= 1'b0;
      if (in_wait && tmo_hit) begin
        // Abort: partial counts are kept, params stay unloaded after a load abort
        load_q   <= 1'b0;
        start_q  <= 1'b0;
        to_err_q <= 1'b1;
        state_q  <= IDLE;
      end else begin
        unique case (state_q)
          IDLE: begin
            tmo_q <= '0;
            if (edge_load) begin
              oh_err_q <= 1'b0;
              to_err_q <= 1'b0;
              loaded_q <= 1'b0;
              load_q   <= 1'b1;
              state_q  <= LOAD_REQ;
            end else if ((edge_sweep || edge_run) && loaded_q) begin
              oh_err_q <= 1'b0;
              to_err_q <= 1'b0;
              done_q   <= '0;
              corr_q   <= '0;
              sweep_q  <= edge_sweep;
              img_q    <= edge_sweep ? '0 : sel_image;
              start_q  <= 1'b1;
              state_q  <= RUN_REQ;
            end
          end
          LOAD_REQ: begin
            if (!rdy_s) begin
              load_q  <= 1'b0;
              tmo_q   <= '0;
              state_q <= LOAD_WAIT;
            end else begin
              tmo_q <= tmo_q + TMO_W'(1);
            end
          end
          LOAD_WAIT: begin
            if (rdy_s) begin
              loaded_q <= 1'b1;
              state_q  <= IDLE;
            end else begin
              tmo_q <= tmo_q + TMO_W'(1);
            end
          end
          RUN_REQ: begin
            if (!rdy_s) begin
              start_q <= 1'b0;
              tmo_q   <= '0;
              state_q <= RUN_WAIT;
            end else begin
              tmo_q <= tmo_q + TMO_W'(1);
            end
          end
          RUN_WAIT: begin
            if (rdy_s) state_q <= CAPTURE;
            else       tmo_q   <= tmo_q + TMO_W'(1);
          end
          CAPTURE: begin
            rv_q   <= 1'b1;
            done_q <= done_q + CNT_W'(1);
            if (cls_ok) begin
              digit_q <= cls_idx;
              if (cls_idx == exp_label) corr_q <= corr_q + CNT_W'(1);
            end else begin
              digit_q  <= 4'hF;
              oh_err_q <= 1'b1;
            end
            state_q <= NEXT;
          end
          NEXT: begin
            if (sweep_q && (img_q != IMG_LAST)) begin
              img_q   <= img_q + IMG_W'(1);
              tmo_q   <= '0;
              start_q <= 1'b1;
              state_q <= RUN_REQ;
            end else begin
              state_q <= IDLE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign sa_load_params = load_q;
  assign sa_start_comp  = start_q;
  assign sa_image_num   = img_q;
  assign result_digit   = digit_q;
  assign result_valid   = rv_q;
  assign params_loaded  = loaded_q;
  assign busy           = (state_q != IDLE);
  assign onehot_err     = oh_err_q;
  assign timeout_err    = to_err_q;
  assign done_cnt       = done_q;
  assign correct_cnt    = corr_q;

endmodule

// File: tb/tb_mnist_run_controller.sv
// Bench for mnist_run_controller: wrapper model plus result scoreboard.
module tb_mnist_run_controller;

  localparam int NI = 16;
  localparam int IW = 4;
  localparam int NC = 10;
  localparam int TMO = 64;
  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_load, cmd_run_one, cmd_sweep;
  logic [IW-1:0] sel_image;
  logic          sa_load_params, sa_start_comp;
  logic [IW-1:0] sa_image_num;
  logic          sa_ready;
  logic [NC-1:0] sa_classes;
  logic [3:0]    exp_label;
  logic [3:0]    result_digit;
  logic          result_valid, params_loaded, busy, onehot_err, timeout_err;
  logic [CW-1:0] done_cnt, correct_cnt;

  always #5 clk = ~clk;

  mnist_run_controller #(
    .N_IMAGES(NI), .IMG_W(IW), .NUM_CLASSES(NC), .TIMEOUT_CYCLES(TMO), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_load(cmd_load), .cmd_run_one(cmd_run_one), .cmd_sweep(cmd_sweep),
    .sel_image(sel_image),
    .sa_load_params(sa_load_params), .sa_start_comp(sa_start_comp),
    .sa_image_num(sa_image_num), .sa_ready(sa_ready), .sa_classes(sa_classes),
    .exp_label(exp_label), .result_digit(result_digit), .result_valid(result_valid),
    .params_loaded(params_loaded), .busy(busy), .onehot_err(onehot_err),
    .timeout_err(timeout_err), .done_cnt(done_cnt), .correct_cnt(correct_cnt)
  );

  logic [3:0] lbl [NI];
  assign exp_label = lbl[sa_image_num];

  typedef struct packed { logic [3:0] digit; logic [3:0] img; } exp_t;
  exp_t sbq[$];

  int n_cmp = 0;
  int n_err = 0;
  int rv_cnt = 0;
  bit load_seen, start_seen, busy_seen;

  bit            fixed_mode = 1'b0;
  logic [NC-1:0] fixed_cls  = '0;
  bit            hang_en    = 1'b0;
  int            hang_img   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", nm, act, req);
    end
  endtask

  // Wrapper model: drops ready 3 cycles after a request, raises it 50 cycles later
  initial begin
    bit         m_run;
    int         m_img;
    logic [NC-1:0] one;
    sa_ready   = 1'b1;
    sa_classes = '0;
    forever begin
      @(negedge clk);
      if (sa_load_params || sa_start_comp) begin
        m_run = sa_start_comp;
        m_img = int'(sa_image_num);
        repeat (3) @(negedge clk);
        sa_ready = 1'b0;
        if (m_run && hang_en && m_img == hang_img)
          while (hang_en) @(negedge clk);
        repeat (50) @(negedge clk);
        if (m_run) begin
          one = NC'(1);
          sa_classes = fixed_mode ? fixed_cls : (one << (m_img % 10));
        end
        sa_ready = 1'b1;
      end
    end
  end

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (sa_load_params) load_seen = 1'b1;
    if (sa_start_comp)  start_seen = 1'b1;
    if (busy)           busy_seen = 1'b1;
    if (sa_load_params && sa_start_comp) begin
      n_cmp++; n_err++;
      $display("FAIL req_exclusive: load=%0b start=%0b, required not both", sa_load_params, sa_start_comp);
    end
    if (result_valid) begin
      rv_cnt++;
      if (sbq.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL unexpected_result: digit %0h img %0d, required no result", result_digit, sa_image_num);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("sb_digit", 32'(result_digit), 32'(e.digit));
        check("sb_img", 32'(sa_image_num), 32'(e.img));
      end
    end
  end

  task automatic pulse(input bit l, input bit r, input bit s);
    @(negedge clk);
    cmd_load = l; cmd_run_one = r; cmd_sweep = s;
    repeat (4) @(negedge clk);
    cmd_load = 1'b0; cmd_run_one = 1'b0; cmd_sweep = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (busy && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (busy) check("idle_wait_expired", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic sweep_labels();
    for (int i = 0; i < NI; i++) lbl[i] = 4'(i % 10);
    lbl[5] = 4'd0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    cmd_load = 1'b0; cmd_run_one = 1'b0; cmd_sweep = 1'b0;
    sel_image = '0;
    for (int i = 0; i < NI; i++) lbl[i] = 4'd0;
    repeat (3) @(negedge clk);
    check("rst_digit", 32'(result_digit), 32'hF);
    check("rst_flags", 32'({sa_load_params, sa_start_comp, result_valid, params_loaded,
                            busy, onehot_err, timeout_err}), 32'd0);
    check("rst_counts", 32'({done_cnt, correct_cnt, sa_image_num}), 32'd0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // run before load is ignored
    busy_seen = 1'b0;
    sel_image = 4'd3;
    pulse(1'b0, 1'b1, 1'b0);
    repeat (10) @(negedge clk);
    check("noload_busy", 32'(busy_seen), 32'd0);
    check("noload_rv", 32'(rv_cnt), 32'd0);

    // load
    load_seen = 1'b0; rv_cnt = 0;
    pulse(1'b1, 1'b0, 1'b0);
    wait_idle(500);
    check("load_req_seen", 32'(load_seen), 32'd1);
    check("load_params_loaded", 32'(params_loaded), 32'd1);
    check("load_req_low", 32'(sa_load_params), 32'd0);
    check("load_busy", 32'(busy), 32'd0);
    check("load_no_result", 32'(rv_cnt), 32'd0);

    // single run, image 7 -> digit 3
    fixed_mode = 1'b1; fixed_cls = 10'b0000001000;
    lbl[7] = 4'd3; sel_image = 4'd7; rv_cnt = 0;
    sbq.push_back('{digit: 4'd3, img: 4'd7});
    pulse(1'b0, 1'b1, 1'b0);
    wait_idle(500);
    check("run1_pulses", 32'(rv_cnt), 32'd1);
    check("run1_digit", 32'(result_digit), 32'd3);
    check("run1_done", 32'(done_cnt), 32'd1);
    check("run1_correct", 32'(correct_cnt), 32'd1);

    // full sweep, image 5 labelled 0
    fixed_mode = 1'b0; sweep_labels(); rv_cnt = 0;
    for (int i = 0; i < NI; i++) sbq.push_back('{digit: 4'(i % 10), img: 4'(i)});
    pulse(1'b0, 1'b0, 1'b1);
    wait_idle(3000);
    check("sweep_pulses", 32'(rv_cnt), 32'd16);
    check("sweep_img", 32'(sa_image_num), 32'd15);
    check("sweep_done", 32'(done_cnt), 32'd16);
    check("sweep_correct", 32'(correct_cnt), 32'd15);
    check("sweep_busy", 32'(busy), 32'd0);

    // malformed: no bit set (label F must not count as correct)
    fixed_mode = 1'b1; fixed_cls = 10'b0000000000;
    sel_image = 4'd2; lbl[2] = 4'hF;
    sbq.push_back('{digit: 4'hF, img: 4'd2});
    pulse(1'b0, 1'b1, 1'b0);
    wait_idle(500);
    check("zero_digit", 32'(result_digit), 32'hF);
    check("zero_onehot_err", 32'(onehot_err), 32'd1);
    check("zero_counts", 32'({done_cnt, correct_cnt}), 32'({5'd1, 5'd0}));
    // malformed: two bits set
    fixed_cls = 10'b0000100001; lbl[2] = 4'd0;
    sbq.push_back('{digit: 4'hF, img: 4'd2});
    pulse(1'b0, 1'b1, 1'b0);
    wait_idle(500);
    check("multi_digit", 32'(result_digit), 32'hF);
    check("multi_onehot_err", 32'(onehot_err), 32'd1);
    check("multi_correct", 32'(correct_cnt), 32'd0);
    // good run clears sticky error
    fixed_cls = 10'b0000000100; lbl[2] = 4'd2;
    sbq.push_back('{digit: 4'd2, img: 4'd2});
    pulse(1'b0, 1'b1, 1'b0);
    wait_idle(500);
    check("clear_onehot_err", 32'(onehot_err), 32'd0);
    check("clear_correct", 32'(correct_cnt), 32'd1);

    // sweep stalls at image 4
    fixed_mode = 1'b0; sweep_labels(); rv_cnt = 0;
    hang_en = 1'b1; hang_img = 4;
    for (int i = 0; i < 4; i++) sbq.push_back('{digit: 4'(i), img: 4'(i)});
    pulse(1'b0, 1'b0, 1'b1);
    wait_idle(2000);
    check("tmo_err", 32'(timeout_err), 32'd1);
    check("tmo_reqs", 32'({sa_load_params, sa_start_comp}), 32'd0);
    check("tmo_busy", 32'(busy), 32'd0);
    check("tmo_done", 32'(done_cnt), 32'd4);
    check("tmo_correct", 32'(correct_cnt), 32'd4);
    check("tmo_img", 32'(sa_image_num), 32'd4);
    check("tmo_pulses", 32'(rv_cnt), 32'd4);
    hang_en = 1'b0;
    begin
      int k = 0;
      while (!sa_ready && k < 200) begin @(negedge clk); k++; end
      check("model_release", 32'(sa_ready), 32'd1);
    end
    repeat (5) @(negedge clk);

    // load and sweep in the same cycle: load only
    start_seen = 1'b0; load_seen = 1'b0; rv_cnt = 0;
    pulse(1'b1, 1'b0, 1'b1);
    wait_idle(500);
    check("prio_load_seen", 32'(load_seen), 32'd1);
    check("prio_no_start", 32'(start_seen), 32'd0);
    check("prio_loaded", 32'(params_loaded), 32'd1);
    check("prio_no_result", 32'(rv_cnt), 32'd0);
    check("prio_done_kept", 32'(done_cnt), 32'd4);
    check("prio_tmo_cleared", 32'(timeout_err), 32'd0);

    check("sb_drained", 32'(sbq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mnist_run_controller.md
Name: mnist_run_controller

Overview:
- Sequencer for the systolic-array MNIST wrapper on the DE10-Lite.
- Turns user switch commands into the wrapper's load_params / start_comp handshake.
- Steps image_num through single or sweep runs and decodes the one-hot class result into a digit.
- Scores each result against an externally supplied expected label and reports timeouts and malformed results.

Parameters:
- N_IMAGES, 16, number of stored test images; sweep covers 0..N_IMAGES-1
- IMG_W, 4, width of image index
- NUM_CLASSES, 10, width of class vector
- TIMEOUT_CYCLES, 1048576, max cycles in any wait state before abort
- CNT_W, $clog2(N_IMAGES+1), width of score counters

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- cmd_load  in  1  level request to load parameters; asynchronous, rising edge acts
- cmd_run_one  in  1  level request to classify sel_image; rising edge acts
- cmd_sweep  in  1  level request to classify all images; rising edge acts
- sel_image  in  IMG_W  image for single run
- sa_load_params  out  1  to wrapper load_params
- sa_start_comp  out  1  to wrapper start_comp
- sa_image_num  out  IMG_W  to wrapper image_num
- sa_ready  in  1  wrapper ready (high = idle/finished)
- sa_classes  in  NUM_CLASSES  wrapper one-hot class result
- exp_label  in  4  expected digit for current sa_image_num (combinational lookup outside)
- result_digit  out  4  last decoded digit, 4'hF if malformed
- result_valid  out  1  one-cycle pulse per captured result
- params_loaded  out  1  parameters successfully loaded
- busy  out  1  FSM not in IDLE
- onehot_err  out  1  sticky: a result was not exactly one-hot
- timeout_err  out  1  sticky: a wait exceeded TIMEOUT_CYCLES
- done_cnt  out  CNT_W  results captured in current run
- correct_cnt  out  CNT_W  results matching exp_label in current run

Behaviour:
- Reset: all outputs 0, except result_digit = 4'hF. FSM goes to IDLE, timeout counter cleared.
- cmd_* and sa_ready pass through 2-FF synchronizers; then rising-edge detect. Edges are acted on only in IDLE; edges seen while busy are dropped.
- Same-cycle priority: load > sweep > run_one.
- run_one/sweep edges with params_loaded=0 are ignored.
- Accepting any command clears onehot_err and timeout_err.
- States: IDLE, LOAD_REQ, LOAD_WAIT, RUN_REQ, RUN_WAIT, CAPTURE, NEXT.
- LOAD_REQ:
  - sa_load_params=1, held until synchronized sa_ready is seen low (ack); then go LOAD_WAIT with request deasserted.
  - Clears params_loaded.
- LOAD_WAIT: on sa_ready high, set params_loaded=1 and go IDLE.
- Run start:
  - run_one: sa_image_num=sel_image (latched at accept).
  - sweep: sa_image_num=0.
  - In both cases done_cnt and correct_cnt are cleared.
- RUN_REQ: sa_start_comp=1 until sa_ready low; then RUN_WAIT.
- RUN_WAIT: sa_ready high -> CAPTURE.
- CAPTURE (one cycle):
  - Decode sa_classes. Exactly one bit i set -> result_digit=i; otherwise result_digit=4'hF and onehot_err set.
  - Pulse result_valid; done_cnt+1.
  - correct_cnt+1 iff result_digit==exp_label and no malformation.
- NEXT:
  - run_one -> IDLE.
  - sweep: if sa_image_num==N_IMAGES-1 -> IDLE (no wrap), else increment and go RUN_REQ.
  - sa_image_num holds its last value in IDLE.
- Timeout:
  - Counter restarts on entry to each REQ/WAIT state.
  - Reaching TIMEOUT_CYCLES: deassert both requests, set timeout_err, go IDLE.
  - A sweep in progress is aborted, and the counters keep their partial values.
  - A load timeout leaves params_loaded=0.
- Invariant: sa_load_params and sa_start_comp are never high simultaneously.
- Output timing: requests are registered outputs; result_valid is registered.
- Reset mid-operation: requests drop immediately (async); params_loaded=0.

Test Plan:
- Reset, then cmd_load rising; wrapper model drops ready 3 cycles after request and raises it 50 cycles later. Required: sa_load_params high until ack, params_loaded=1, busy returns 0, no result_valid.
- cmd_run_one with sel_image=7, model returns classes=10'b0000001000, exp_label=3. Required: one result_valid pulse, result_digit=3, done_cnt=1, correct_cnt=1.
- cmd_sweep, model returns digit (img mod 10), exp_label=img mod 10 except img 5 (label 0). Required: 16 pulses, sa_image_num 0..15, then IDLE with sa_image_num=15, done_cnt=16, correct_cnt=15.
- Run with classes=10'b0000000000, then 10'b0000100001. Required: result_digit=4'hF, onehot_err=1, correct_cnt unchanged; next accepted command clears onehot_err.
- Sweep where the model never raises ready at image 4 (TIMEOUT_CYCLES=64 in bench). Required: timeout_err=1, requests low, IDLE, done_cnt=4.
- cmd_run_one before any load, plus cmd_load and cmd_sweep edges in the same cycle after load. Required: first run ignored (busy stays 0); simultaneous edges start load only.
